// File: rtl/lcd_char_sequencer_if.sv
// rtl/lcd_char_sequencer_if.sv - character feed, status and byte-driver handshake bundle
interface lcd_char_sequencer_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             clear_req;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             init_done;
    logic             ready;
    logic             drv_start;
    logic             drv_rs;
    logic [7:0]       drv_data;
    logic             drv_done;

    modport master (
        output wr_en, wr_data, clear_req, drv_done,
        input  fifo_full, fifo_count, init_done, ready, drv_start, drv_rs, drv_data
    );

    modport slave (
        input  wr_en, wr_data, clear_req, drv_done,
        output fifo_full, fifo_count, init_done, ready, drv_start, drv_rs, drv_data
    );
endinterface

// File: rtl/lcd_char_sequencer.sv
// rtl/lcd_char_sequencer.sv - HD44780 init, character FIFO drain and line wrapping over a start/done byte handshake
module lcd_char_sequencer #(
    parameter int FIFO_DEPTH        = 16,
    parameter int POWERUP_CYCLES    = 2_500_000,
    parameter int CLEAR_WAIT_CYCLES = 100_000,
    parameter int COLS              = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_char_sequencer_if.slave   bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int COL_W = $clog2(2 * COLS);
    localparam int TMAX  = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_ISSUE, INIT_WAIT, CLR_ISSUE, CLR_WAIT, CLR_HOLD,
        IDLE, CHAR_ISSUE, CHAR_WAIT, ADDR_ISSUE, ADDR_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       init_idx_q, init_idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             pend_q, pend_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             init_done_q, init_done_d;
    logic             ready_q, ready_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             push, pop;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return 8'h38;
            3'd2:       return 8'h0C;
            3'd3:       return 8'h06;
            default:    return 8'h01;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        init_idx_d  = init_idx_q;
        col_d       = col_q;
        pend_d      = pend_q | bus.clear_req;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        pop         = 1'b0;
        push        = bus.wr_en & ~full_q;

        case (state_q)
            PWR_WAIT: begin
                if (timer_q == TW'(POWERUP_CYCLES - 1)) begin
                    state_d    = INIT_ISSUE;
                    init_idx_d = 3'd0;
                    rs_d       = 1'b0;
                    data_d     = init_rom(3'd0);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            INIT_ISSUE: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (bus.drv_done) begin
                    if (init_idx_q == 3'd4) begin
                        state_d = CLR_HOLD;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        data_d     = init_rom(init_idx_q + 3'd1);
                        state_d    = INIT_ISSUE;
                    end
                end
            end
            CLR_ISSUE: state_d = CLR_WAIT;
            CLR_WAIT:  if (bus.drv_done) state_d = CLR_HOLD;
            // Shared by the init-time clear and user clears; both leave the cursor at home.
            CLR_HOLD: begin
                if (timer_q == TW'(CLEAR_WAIT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    col_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    rs_d    = 1'b0;
                    data_d  = 8'h01;
                    state_d = CLR_ISSUE;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    rs_d    = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = CHAR_ISSUE;
                end
            end
            CHAR_ISSUE: state_d = CHAR_WAIT;
            CHAR_WAIT: begin
                if (bus.drv_done) begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d   = COL_W'(COLS);
                        rs_d    = 1'b0;
                        data_d  = 8'hC0;
                        state_d = ADDR_ISSUE;
                    end else if (col_q == COL_W'(2 * COLS - 1)) begin
                        col_d   = '0;
                        rs_d    = 1'b0;
                        data_d  = 8'h80;
                        state_d = ADDR_ISSUE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ADDR_ISSUE: state_d = ADDR_WAIT;
            ADDR_WAIT:  if (bus.drv_done) state_d = IDLE;
            default:    state_d = PWR_WAIT;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        full_d  = (count_d == CW'(FIFO_DEPTH));
        ready_d = init_done_d & (state_d == IDLE) & (count_d == '0) & ~pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PWR_WAIT;
            timer_q     <= '0;
            init_idx_q  <= '0;
            col_q       <= '0;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            init_idx_q  <= init_idx_d;
            col_q       <= col_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.drv_start  = (state_q == INIT_ISSUE) | (state_q == CLR_ISSUE) |
                            (state_q == CHAR_ISSUE) | (state_q == ADDR_ISSUE);
    assign bus.drv_rs     = rs_q;
    assign bus.drv_data   = data_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.init_done  = init_done_q;
    assign bus.ready      = ready_q;
endmodule
